redundancy_sel_gen: RTL and testbench
=====================================

Name: redundancy_sel_gen

Overview:
- Sequential select generator that drives the `sel` inputs of a bank of N-to-1 word muxes. There is one mux per logical lane, and each mux chooses among PHYS_LANES physical lanes.
- Accepts a per-lane fault map through a valid/ready handshake and scans it one physical lane per cycle.
- Assigns healthy physical lanes in ascending order to logical lanes 0..LOG_LANES-1, then commits the new steering atomically.
- Sits directly upstream of the mux bank. Each `sel_flat` slice connects to one mux `sel` port.

Parameters:
- PHYS_LANES, 8, number of physical lanes (mux inputs); must be ≥ LOG_LANES and ≥ 2.
- LOG_LANES, 6, number of logical lanes (mux instances); PHYS_LANES-LOG_LANES spares.
- SEL_WIDTH, 3, select width per mux; must satisfy 2**SEL_WIDTH ≥ PHYS_LANES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  fault map offered.
- cfg_ready  output  1  block idle and able to accept a fault map.
- fault_map  input  PHYS_LANES  bit p=1 marks physical lane p faulty; sampled only on handshake.
- sel_flat  output  LOG_LANES*SEL_WIDTH  committed selects; logical lane i at [i*SEL_WIDTH +: SEL_WIDTH].
- map_ok  output  1  1 when the last commit (or reset) produced a full mapping.
- done  output  1  one-cycle pulse at commit.
- healthy_cnt  output  SEL_WIDTH+1  count of healthy lanes found by the last completed scan.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE, cfg_ready=1, done=0, map_ok=1, healthy_cnt=PHYS_LANES.
  - sel_flat = identity (slice i = i).
  - Shadow table, scan pointer and assign counter cleared; a scan in progress is discarded.
- States: IDLE, SCAN, COMMIT.
- Handshake:
  - Accepted at edge E0 when cfg_valid && cfg_ready (cfg_ready = state==IDLE).
  - fault_map registered; ptr=0, cnt=0; state→SCAN.
  - cfg_valid while busy is ignored; no queuing.
- SCAN: at each edge E1..E_PHYS_LANES, process ptr:
  - If lane ptr is healthy: hc++.
  - If lane ptr is healthy and cnt<LOG_LANES: shadow[cnt]=ptr, cnt++.
  - Healthy lanes beyond LOG_LANES are counted but not assigned.
  - ptr++. After ptr=PHYS_LANES-1 is processed, state→COMMIT.
- COMMIT, at edge E_(PHYS_LANES+1):
  - If cnt==LOG_LANES: sel_flat←shadow, map_ok←1.
  - Otherwise: sel_flat unchanged (previous mapping retained), map_ok←0.
  - healthy_cnt←hc; done=1 for that cycle only; state→IDLE (cfg_ready=1 in the same cycle as done).
- Latency: new sel_flat visible PHYS_LANES+1 edges after the handshake edge. With defaults, 9 edges; a back-to-back request is accepted on the done cycle.
- sel_flat never changes except at a successful COMMIT or at reset. Partial shadow contents are never visible.
- The assigned mapping is strictly increasing in physical index, which preserves lane order.
- All-zero fault map gives the identity mapping. An all-ones fault map gives map_ok=0 and healthy_cnt=0.
- Widths: cnt and hc are SEL_WIDTH+1 bits wide; ptr is SEL_WIDTH+1 bits wide to avoid wrap at PHYS_LANES=2**SEL_WIDTH.

Optional Feature:
- Macro: REDUN_FAULT_STICKY_EN.
- Defined: an internal accumulated fault register (reset 0) is OR-ed with each accepted fault_map. The scan uses the accumulated value, so a lane once flagged stays excluded until reset.
- Undefined: each scan uses only the fault_map captured at its handshake; there is no accumulated register.

Test Plan:
- Reset: assert reset mid-cycle → immediately sel_flat slices = 0,1,2,3,4,5; map_ok=1; cfg_ready=1; done=0.
- fault_map=8'h00 → done exactly 9 edges after handshake; sel=0,1,2,3,4,5; map_ok=1; healthy_cnt=8.
- fault_map=8'h04 → sel=0,1,3,4,5,6; map_ok=1; healthy_cnt=7. Then fault_map=8'h81 → sel=1,2,3,4,5,6; healthy_cnt=6.
- fault_map=8'h15 (3 faulty) → map_ok=0; healthy_cnt=5; sel_flat keeps the previous mapping. cfg_valid held during SCAN is not accepted (cfg_ready=0).
- Assert reset during SCAN after fault_map=8'h04 → identity restored; no done pulse. Next request 8'h00 completes normally.
- With REDUN_FAULT_STICKY_EN: 8'h04, then 8'h40 → second commit gives sel=0,1,3,4,5,7. Without the macro the same sequence gives sel=0,1,2,3,4,5.

Source files
------------

// File: rtl/redundancy_sel_gen.sv
// redundancy_sel_gen: scans a lane fault map and commits ascending healthy-lane selects to a mux bank.
// Optional REDUN_FAULT_STICKY_EN: accepted fault maps accumulate until reset.
module redundancy_sel_gen #(
    parameter int PHYS_LANES = 8,
    parameter int LOG_LANES  = 6,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    input  logic [PHYS_LANES-1:0]          fault_map,
    output logic [LOG_LANES*SEL_WIDTH-1:0] sel_flat,
    output logic                           map_ok,
    output logic                           done,
    output logic [SEL_WIDTH:0]             healthy_cnt
);
    localparam logic [SEL_WIDTH:0] LOG_N     = (SEL_WIDTH+1)'(LOG_LANES);
    localparam logic [SEL_WIDTH:0] PHYS_N    = (SEL_WIDTH+1)'(PHYS_LANES);
    localparam logic [SEL_WIDTH:0] PHYS_LAST = (SEL_WIDTH+1)'(PHYS_LANES-1);

    function automatic logic [LOG_LANES*SEL_WIDTH-1:0] ident_map();
        ident_map = '0;
        for (int i = 0; i < LOG_LANES; i++) ident_map[i*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(i);
    endfunction

    localparam logic [LOG_LANES*SEL_WIDTH-1:0] IDENT = ident_map();

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t                         state;
    logic [PHYS_LANES-1:0]          fmap;
    logic [LOG_LANES*SEL_WIDTH-1:0] shadow;
    logic [SEL_WIDTH:0]             ptr, cnt, hc;

    assign cfg_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            fmap        <= '0;
            shadow      <= '0;
            ptr         <= '0;
            cnt         <= '0;
            hc          <= '0;
            sel_flat    <= IDENT;
            map_ok      <= 1'b1;
            done        <= 1'b0;
            healthy_cnt <= PHYS_N;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (cfg_valid) begin
`ifdef REDUN_FAULT_STICKY_EN
                    fmap  <= fmap | fault_map;
`else
                    fmap  <= fault_map;
`endif
                    ptr   <= '0;
                    cnt   <= '0;
                    hc    <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    // surplus healthy lanes are counted but never assigned
                    if (!fmap[ptr[SEL_WIDTH-1:0]]) begin
                        hc <= hc + 1'b1;
                        if (cnt < LOG_N) begin
                            shadow[cnt*SEL_WIDTH +: SEL_WIDTH] <= ptr[SEL_WIDTH-1:0];
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ptr <= ptr + 1'b1;
                    if (ptr == PHYS_LAST) state <= COMMIT;
                end
                COMMIT: begin
                    if (cnt == LOG_N) sel_flat <= shadow;
                    map_ok      <= (cnt == LOG_N);
                    healthy_cnt <= hc;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_redundancy_sel_gen.sv
// tb_redundancy_sel_gen: scoreboard bench for redundancy_sel_gen (default parameters).
module tb_redundancy_sel_gen;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  fault_map = '0;
    logic [17:0] sel_flat;
    logic        map_ok;
    logic        done;
    logic [3:0]  healthy_cnt;

    typedef struct {
        logic [17:0] sel;
        logic        ok;
        logic [3:0]  hc;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  acc_m = '0;
    logic [17:0] cur_sel;
    logic [17:0] ident;
    int          pass_cnt = 0;
    int          total = 0;

    redundancy_sel_gen dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .fault_map(fault_map), .sel_flat(sel_flat), .map_ok(map_ok), .done(done),
        .healthy_cnt(healthy_cnt)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [7:0] fm);
        logic [7:0]  eff;
        logic [17:0] s;
        exp_t        e;
        int          c;
`ifdef REDUN_FAULT_STICKY_EN
        acc_m = acc_m | fm;
        eff   = acc_m;
`else
        eff   = fm;
`endif
        s = '0; c = 0; e.hc = '0;
        for (int p = 0; p < 8; p++) begin
            if (!eff[p]) begin
                if (c < 6) s[c*3 +: 3] = 3'(p);
                c++;
                e.hc = e.hc + 4'd1;
            end
        end
        e.ok = (c >= 6);
        if (e.ok) cur_sel = s;
        e.sel = cur_sel;
        q.push_back(e);
    endtask

    task automatic offer(input logic [7:0] fm, input string name);
        cfg_valid = 1'b1;
        fault_map = fm;
        total++;
        if (cfg_ready !== 1'b1) $display("FAIL %s ready: got %b want 1", name, cfg_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        push_exp(fm);
    endtask

    task automatic wait_done(input string name, input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (done !== 1'b1 || n != lat) $display("FAIL %s latency: got %0d edges done=%b want %0d", name, n, done, lat);
        else pass_cnt++;
        e = q.pop_front();
        total++;
        if (sel_flat !== e.sel) $display("FAIL %s sel: got %h want %h", name, sel_flat, e.sel);
        else pass_cnt++;
        total++;
        if (map_ok !== e.ok) $display("FAIL %s map_ok: got %b want %b", name, map_ok, e.ok);
        else pass_cnt++;
        total++;
        if (healthy_cnt !== e.hc) $display("FAIL %s healthy_cnt: got %0d want %0d", name, healthy_cnt, e.hc);
        else pass_cnt++;
    endtask

    task automatic request(input logic [7:0] fm, input string name);
        @(negedge clk);
        offer(fm, name);
        wait_done(name, 9);
    endtask

    task automatic check_reset_state(input string name);
        total++;
        if ({sel_flat, map_ok, cfg_ready, done, healthy_cnt} !== {ident, 1'b1, 1'b1, 1'b0, 4'd8})
            $display("FAIL %s: got sel=%h ok=%b rdy=%b done=%b hc=%0d want sel=%h ok=1 rdy=1 done=0 hc=8",
                     name, sel_flat, map_ok, cfg_ready, done, healthy_cnt, ident);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1 check_reset_state("reset");
    endtask

    task automatic test_identity();
        request(8'h00, "identity");
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) $display("FAIL done_pulse: got %b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_faults();
        request(8'h04, "fault_04");
        request(8'h81, "fault_81");
    endtask

    task automatic test_insufficient_busy();
        @(negedge clk);
        offer(8'h15, "fault_15");
        cfg_valid = 1'b1;
        fault_map = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (cfg_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", cfg_ready);
        else pass_cnt++;
        wait_done("fault_15", 5);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset_during_scan();
        int pulses;
        @(negedge clk);
        cfg_valid = 1'b1;
        fault_map = 8'h04;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        cur_sel = ident;
        acc_m   = '0;
        #1 check_reset_state("reset_mid_scan");
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) $display("FAIL aborted_done: got %0d pulses want 0", pulses);
        else pass_cnt++;
        request(8'h00, "after_reset");
    endtask

    task automatic test_sticky();
        request(8'h04, "sticky_04");
        request(8'h40, "sticky_40");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        offer(8'h04, "b2b_first");
        wait_done("b2b_first", 9);
        offer(8'h81, "b2b_second");
        wait_done("b2b_second", 9);
    endtask

    task automatic test_all_faulty();
        request(8'hFF, "all_faulty");
    endtask

    initial begin
        for (int i = 0; i < 6; i++) ident[i*3 +: 3] = 3'(i);
        cur_sel = ident;
        test_reset();
        test_identity();
        test_faults();
        test_insufficient_busy();
        test_reset_during_scan();
        test_sticky();
        test_back_to_back();
        test_all_faulty();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
